conv_engine: RTL and testbench
==============================

Name: conv_engine

Overview:
- Parametrised successor to the fixed 5x5 / 16-kernel / Q16 convolution datapath.
- Stores up to KNL_MAXNUM kernels of KNL_DIM x KNL_DIM signed fixed-point weights. Convolves each streamed KNL_DIM x KNL_DIM input window with every stored kernel.
- Emits one output per kernel (channel) with optional partial-sum accumulation, ReLU and saturation. All I/O uses valid/ready streams.
- Sits between the DRAM read/write sequencer and the layer controller.

Parameters:
- DATA_WIDTH, 32: signed fixed-point word width.
- FRAC_BITS, 16: fractional bits (Qm.FRAC_BITS).
- KNL_DIM, 5: kernel and window edge length; KNL_DIM*KNL_DIM words per kernel.
- KNL_MAXNUM, 16: maximum number of stored kernels.
- CNT_WIDTH, 5: width of num_knls and out_chnl; must hold KNL_MAXNUM.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- num_knls  in  CNT_WIDTH  kernel count (0..KNL_MAXNUM); latched on start.
- relu_en  in  1  clamp negative results to 0; latched on start.
- acc_en  in  1  add a streamed partial sum per output; latched on start.
- in_valid  in  1  input stream valid.
- in_data  in  DATA_WIDTH  carries kernel words, window words or partial sums, depending on state.
- in_last  in  1  marks the final word of the final window; sampled with that word only.
- in_ready  out  1  input stream ready.
- out_valid  out  1  result valid.
- out_data  out  DATA_WIDTH  registered result.
- out_chnl  out  CNT_WIDTH  kernel index of out_data.
- out_ready  in  1  downstream ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of job.

Behaviour:
- Reset:
  - state goes to IDLE.
  - in_ready, out_valid, busy, done, out_data, out_chnl and all counters/accumulator are 0.
  - Kernel and window storage are not reset, so kernels must be reloaded after any reset. Reset mid-operation abandons the job without emitting done.
- Input transfers happen only when in_valid and in_ready are both high. Output transfers happen only when out_valid and out_ready are both high.
- States:
  - IDLE:
    - in_ready=0.
    - start with num_knls=0 pulses done in the next cycle and stays in IDLE.
    - start with num_knls>0 latches the configuration and goes to LD_KNL.
    - start in any other state is ignored.
  - LD_KNL:
    - in_ready=1; accepts num_knls*KNL_DIM^2 words.
    - Order: kernel 0 first, each kernel row-major.
    - After the last word, go to LD_WIN.
  - LD_WIN:
    - in_ready=1; accepts KNL_DIM^2 words row-major.
    - in_last is captured with the final word.
    - Then ch=0, acc=0, go to MAC.
  - MAC:
    - Runs KNL_DIM cycles with row index r = 0..KNL_DIM-1.
    - Each cycle: acc += sum over c of ((knl[ch][r][c] * win[r][c]) >>> FRAC_BITS).
    - After r=KNL_DIM-1, go to PSUM if acc_en, else OUT.
  - PSUM:
    - in_ready=1; accepts one partial-sum word and adds it to acc.
    - Then go to OUT.
  - OUT:
    - out_data = sat(acc), followed by ReLU if enabled; out_chnl=ch.
    - Both are registered on entry; out_valid=1.
    - out_data and out_chnl stay stable until the handshake.
    - On handshake:
      - if ch < num_knls-1: ch++, acc=0, go to MAC;
      - else if the captured in_last=1: pulse done and go to IDLE;
      - else go to LD_WIN.
- Arithmetic:
  - Products are full 2*DATA_WIDTH signed.
  - The shift is arithmetic, i.e. floor toward negative infinity.
  - acc is 2*DATA_WIDTH+6 bits wide, so it cannot overflow.
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - ReLU is applied after saturation.
- Latency:
  - Without acc_en: out_valid rises KNL_DIM+1 cycles after the last window word is accepted.
  - With acc_en: out_valid rises 1 cycle after the partial sum is accepted.
  - Each subsequent channel becomes valid KNL_DIM+1 cycles after the previous handshake.
- Kernels persist across windows within a job. Each new start reloads them.
- in_ready is never high in MAC or OUT, so back-pressure never loses data.

Test Plan:
1. KNL_DIM=5, num_knls=1, all weights 0x00010000 (1.0), window all 0x00020000, in_last=1 -> out_data=0x00320000, out_chnl=0; out_valid 6 cycles after the last window word; done one cycle after the handshake.
2. num_knls=2, kernel 1 all 0xFFFF0000 (-1.0), same window:
   - relu_en=0 -> chnl0=0x00320000, chnl1=0xFFCE0000;
   - repeat with relu_en=1 -> chnl1=0x00000000.
3. Saturation: weights and window all 0x7FFF0000 -> out_data=0x7FFFFFFF; weights 0x80000000 (-32768.0) with the same window -> 0x80000000.
4. acc_en=1 with the case-1 data, partial sum 0x00010000 -> out_data=0x00330000; in_ready high only in PSUM between MAC and OUT. Two windows (in_last=0 then 1) -> two outputs, then done.
5. Back-pressure and edge cases:
   - hold out_ready=0 for 7 cycles -> out_data and out_chnl stable, in_ready=0 throughout;
   - start with num_knls=0 -> done next cycle, busy stays 0;
   - start while busy -> ignored.
6. Assert rst during MAC -> all outputs 0 immediately with no done; a fresh start with reloaded kernels reproduces the case-1 result.

Source files
------------

// File: rtl/conv_engine.sv
// Streaming KxK convolution engine: stores up to KNL_MAXNUM kernels, convolves
// each streamed window with every kernel, optional partial-sum, ReLU, saturation.
module conv_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int KNL_DIM    = 5,
  parameter int KNL_MAXNUM = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_knls,
  input  logic                  relu_en,
  input  logic                  acc_en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_chnl,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int NW  = KNL_DIM * KNL_DIM;
  localparam int PW  = 2 * DATA_WIDTH;
  localparam int AW  = PW + 6;
  localparam int KAW = $clog2(KNL_MAXNUM * NW);
  localparam int WAW = $clog2(NW);
  localparam int RW  = (KNL_DIM > 1) ? $clog2(KNL_DIM) : 1;

  localparam logic signed [AW-1:0] SAT_HI =
    AW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [2:0] {
    IDLE, LD_KNL, LD_WIN, MAC, PSUM, OUT
  } state_t;

  state_t state;

  logic signed [DATA_WIDTH-1:0] knl_mem [KNL_MAXNUM*NW];
  logic signed [DATA_WIDTH-1:0] win_mem [NW];

  logic [KAW-1:0]       kaddr;
  logic [KAW-1:0]       klast;
  logic [WAW-1:0]       waddr;
  logic [RW-1:0]        row;
  logic [CNT_WIDTH-1:0] ch;
  logic [CNT_WIDTH-1:0] nk;
  logic [CNT_WIDTH-1:0] nk_in;
  logic                 relu_q;
  logic                 accen_q;
  logic                 last_q;

  logic signed [AW-1:0]         acc;
  logic signed [AW-1:0]         acc_nxt;
  logic signed [AW-1:0]         row_sum;
  logic signed [PW-1:0]         prod [KNL_DIM];
  logic signed [PW-1:0]         shf  [KNL_DIM];
  logic signed [DATA_WIDTH-1:0] res;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign nk_in = (num_knls > CNT_WIDTH'(KNL_MAXNUM)) ?
                 CNT_WIDTH'(KNL_MAXNUM) : num_knls;

  // One kernel row per cycle: KNL_DIM full-width products, each rescaled.
  always_comb begin
    row_sum = '0;
    for (int c = 0; c < KNL_DIM; c++) begin
      prod[c] = knl_mem[KAW'(int'(ch) * NW + int'(row) * KNL_DIM + c)]
              * win_mem[WAW'(int'(row) * KNL_DIM + c)];
      shf[c]  = prod[c] >>> FRAC_BITS;
      row_sum = row_sum + AW'(shf[c]);
    end
  end

  always_comb begin
    acc_nxt = acc + row_sum;
    if (state == PSUM)
      acc_nxt = acc + AW'($signed(in_data));
  end

  always_comb begin
    res = acc_nxt[DATA_WIDTH-1:0];
    if (acc_nxt > SAT_HI)
      res = SAT_HI[DATA_WIDTH-1:0];
    else if (acc_nxt < SAT_LO)
      res = SAT_LO[DATA_WIDTH-1:0];
    if (relu_q && res[DATA_WIDTH-1])
      res = '0;
  end

  // Storage is deliberately unreset; a job always reloads it.
  always_ff @(posedge clk) begin
    if (state == LD_KNL && in_fire)
      knl_mem[kaddr] <= $signed(in_data);
    if (state == LD_WIN && in_fire)
      win_mem[waddr] <= $signed(in_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chnl  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      kaddr     <= '0;
      klast     <= '0;
      waddr     <= '0;
      row       <= '0;
      ch        <= '0;
      nk        <= '0;
      relu_q    <= 1'b0;
      accen_q   <= 1'b0;
      last_q    <= 1'b0;
      acc       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (num_knls == '0) begin
              done <= 1'b1;
            end else begin
              nk       <= nk_in;
              klast    <= KAW'(int'(nk_in) * NW - 1);
              relu_q   <= relu_en;
              accen_q  <= acc_en;
              kaddr    <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= LD_KNL;
            end
          end
        end
        LD_KNL: begin
          if (in_fire) begin
            kaddr <= kaddr + 1'b1;
            if (kaddr == klast) begin
              kaddr <= '0;
              waddr <= '0;
              state <= LD_WIN;
            end
          end
        end
        LD_WIN: begin
          if (in_fire) begin
            waddr <= waddr + 1'b1;
            if (waddr == WAW'(NW - 1)) begin
              last_q   <= in_last;
              ch       <= '0;
              acc      <= '0;
              row      <= '0;
              in_ready <= 1'b0;
              state    <= MAC;
            end
          end
        end
        MAC: begin
          acc <= acc_nxt;
          row <= row + 1'b1;
          if (row == RW'(KNL_DIM - 1)) begin
            row <= '0;
            if (accen_q) begin
              in_ready <= 1'b1;
              state    <= PSUM;
            end else begin
              out_valid <= 1'b1;
              out_data  <= res;
              out_chnl  <= ch;
              state     <= OUT;
            end
          end
        end
        PSUM: begin
          if (in_fire) begin
            acc       <= acc_nxt;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= res;
            out_chnl  <= ch;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            if (ch < nk - 1'b1) begin
              ch    <= ch + 1'b1;
              acc   <= '0;
              row   <= '0;
              state <= MAC;
            end else if (last_q) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              waddr    <= '0;
              in_ready <= 1'b1;
              state    <= LD_WIN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_engine.sv
// Directed bench for conv_engine; expected outputs are queued at stimulus
// time and checked by an independent output monitor.
module tb_conv_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  num_knls = '0;
  logic        relu_en = 1'b0;
  logic        acc_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_chnl;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  c;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  conv_engine dut (
    .clk(clk), .rst(rst), .start(start), .num_knls(num_knls),
    .relu_en(relu_en), .acc_en(acc_en), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chnl(out_chnl),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h chnl %0d expected none",
                 out_data, out_chnl);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", {32'h0, out_data}, {32'h0, e.d});
        chk("out_chnl", {59'h0, out_chnl}, {59'h0, e.c});
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_start(input int n, input logic r, input logic a);
    sync();
    start = 1'b1;
    num_knls = 5'(n);
    relu_en = r;
    acc_en = a;
    sync();
    start = 1'b0;
  endtask

  task automatic load_knl(input logic [31:0] v);
    for (int i = 0; i < 25; i++) send(v, 1'b0);
  endtask

  task automatic send_win(input logic [31:0] v, input logic l);
    for (int i = 0; i < 25; i++) send(v, (i == 24) ? l : 1'b0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
  endtask

  task automatic wait_done(input string nm);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    chk(nm, {63'h0, seen}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int errs;
    logic [31:0] d0;
    logic [4:0]  c0;

    repeat (2) @(negedge clk);
    chk("reset_ctl", {60'h0, in_ready, out_valid, busy, done}, 64'd0);
    chk("reset_data", {27'h0, out_chnl, out_data}, 64'd0);
    rst = 1'b0;

    // 1: single kernel, 25 * (1.0 * 2.0) = 50.0
    do_start(1, 1'b0, 1'b0);
    load_knl(32'h0001_0000);
    q.push_back('{32'h0032_0000, 5'd0});
    send_win(32'h0002_0000, 1'b1);
    wait_valid(n);
    chk("t1_latency", 64'(n), 64'd6);
    @(negedge clk);
    chk("t1_done", {63'h0, done}, 64'd1);
    @(negedge clk);
    chk("t1_idle", {62'h0, done, busy}, 64'd0);

    // 2: two kernels, +1.0 and -1.0, without and with ReLU
    do_start(2, 1'b0, 1'b0);
    load_knl(32'h0001_0000);
    load_knl(32'hFFFF_0000);
    q.push_back('{32'h0032_0000, 5'd0});
    q.push_back('{32'hFFCE_0000, 5'd1});
    send_win(32'h0002_0000, 1'b1);
    wait_done("t2_done");
    do_start(2, 1'b1, 1'b0);
    load_knl(32'h0001_0000);
    load_knl(32'hFFFF_0000);
    q.push_back('{32'h0032_0000, 5'd0});
    q.push_back('{32'h0000_0000, 5'd1});
    send_win(32'h0002_0000, 1'b1);
    wait_done("t2r_done");

    // 3: positive and negative saturation
    do_start(1, 1'b0, 1'b0);
    load_knl(32'h7FFF_0000);
    q.push_back('{32'h7FFF_FFFF, 5'd0});
    send_win(32'h7FFF_0000, 1'b1);
    wait_done("t3p_done");
    do_start(1, 1'b0, 1'b0);
    load_knl(32'h8000_0000);
    q.push_back('{32'h8000_0000, 5'd0});
    send_win(32'h7FFF_0000, 1'b1);
    wait_done("t3n_done");

    // 4: partial sums over two windows
    do_start(1, 1'b0, 1'b1);
    load_knl(32'h0001_0000);
    q.push_back('{32'h0033_0000, 5'd0});
    send_win(32'h0002_0000, 1'b0);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready) errs++;
    end
    chk("t4_mac_rdy", 64'(errs), 64'd0);
    @(negedge clk);
    chk("t4_psum_rdy", {62'h0, in_ready, out_valid}, 64'd2);
    sync();
    send(32'h0001_0000, 1'b0);
    @(negedge clk);
    chk("t4_psum_lat", {62'h0, in_ready, out_valid}, 64'd1);
    q.push_back('{32'h0031_0000, 5'd0});
    sync();
    send_win(32'h0002_0000, 1'b1);
    send(32'hFFFF_0000, 1'b0);
    wait_done("t4_done");

    // 5: back-pressure with a start pulse while busy
    do_start(2, 1'b0, 1'b0);
    load_knl(32'h0001_0000);
    load_knl(32'hFFFF_0000);
    out_ready = 1'b0;
    q.push_back('{32'h0032_0000, 5'd0});
    q.push_back('{32'hFFCE_0000, 5'd1});
    send_win(32'h0002_0000, 1'b1);
    wait_valid(n);
    d0 = out_data;
    c0 = out_chnl;
    chk("t5_first", {27'h0, c0, d0}, {27'h0, 5'd0, 32'h0032_0000});
    errs = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (out_data !== d0 || out_chnl !== c0 || in_ready || !out_valid ||
          done || !busy) errs++;
      if (i == 2) begin
        start = 1'b1;
        num_knls = 5'd0;
      end
      if (i == 3) start = 1'b0;
    end
    chk("t5_stall", 64'(errs), 64'd0);
    out_ready = 1'b1;
    wait_done("t5_done");
    do_start(0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_zero_done", {62'h0, done, busy}, 64'd2);
    @(negedge clk);
    chk("t5_zero_after", {62'h0, done, busy}, 64'd0);

    // 6: reset in the middle of MAC, then a clean rerun
    do_start(1, 1'b0, 1'b0);
    load_knl(32'h0001_0000);
    send_win(32'h0002_0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_ctl", {60'h0, in_ready, out_valid, busy, done}, 64'd0);
    chk("t6_rst_data", {27'h0, out_chnl, out_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || out_valid || busy) errs++;
    end
    chk("t6_quiet", 64'(errs), 64'd0);
    do_start(1, 1'b0, 1'b0);
    load_knl(32'h0001_0000);
    q.push_back('{32'h0032_0000, 5'd0});
    send_win(32'h0002_0000, 1'b1);
    wait_done("t6_done");

    repeat (3) @(negedge clk);
    chk("queue_drain", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
